lstm_seq_ctrl: RTL and testbench
================================

// Module: lstm_seq_ctrl
// PURPOSE
//  Sequencer for one LSTM cell over an input sequence of i_len time steps. Accepts x vectors
//  on a valid/ready stream, presents {h(t-1), x} to the cell, waits the cell evaluation latency,
//  emits h(t)/c(t) on an output stream and owns the h(t-1) recurrent register.
//  Sits between the sample feeder and lstm_cell; replaces free-running h feedback with stepped feedback.
// PARAMETERS
//  WIDTH  32  fixed-point word width (cell data format)
//  NUM    3   cell input count incl. h(t-1); x carries NUM-1 words
//  LAT    2   cell evaluation cycles from stable inputs to valid i_h/i_c; legal range 1..255
//  TW     8   step counter / sequence length width
// PORTS
//  clk        in   1             clock, all state on posedge
//  rst        in   1             asynchronous, active-low reset
//  i_start    in   1             start a sequence; sampled only in IDLE
//  i_len      in   TW            number of steps; latched on accepted start
//  i_x_valid  in   1             x vector valid
//  i_x        in   (NUM-1)*WIDTH x vector for current step
//  o_x_ready  out  1             ready for x (high only in LOAD)
//  o_cell_x   out  NUM*WIDTH     {o_hprev, x_reg} to cell i_x
//  o_sel      out  1             0 on step 0, 1 on later steps (cell sel)
//  i_h        in   WIDTH         cell h(t)
//  i_c        in   WIDTH         cell c(t)
//  o_h_valid  out  1             output h/c valid
//  i_h_ready  in   1             downstream accepts h/c
//  o_h        out  WIDTH         captured h(t); o_c out WIDTH captured c(t)
//  o_step     out  TW            index of current step
//  o_last     out  1             high with o_h_valid on step i_len-1
//  o_busy     out  1             high in every state except IDLE
//  o_done     out  1             one-cycle pulse when sequence completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; x_reg, h_prev, o_h, o_c, o_step, len_reg = 0; all
//   valid/ready/busy/done/sel/last outputs 0. Reset mid-sequence aborts it, no o_done.
//  States: IDLE -> LOAD -> EVAL -> EMIT -> (LOAD | DONE) -> IDLE.
//  IDLE: on i_start: len_reg<=i_len, o_step<=0; i_len==0 -> DONE (no steps), else LOAD.
//  LOAD: o_x_ready=1; on i_x_valid&o_x_ready: x_reg<=i_x, lat_cnt<=0, -> EVAL.
//  EVAL: inputs to cell held constant; lat_cnt counts; on cycle where lat_cnt==LAT-1:
//   o_h<=i_h, o_c<=i_c, h_prev<=i_h, -> EMIT. Total latency x-accept -> o_h_valid = LAT+1 clk.
//  EMIT: o_h_valid=1, o_h/o_c/o_last stable until i_h_ready. On handshake:
//   o_step==len_reg-1 -> DONE; else o_step<=o_step+1, -> LOAD. Ready asserted on entry
//   completes in one cycle (no bubble beyond state change).
//  DONE: o_done=1 for exactly this cycle, -> IDLE. i_start in DONE is ignored.
//  o_sel = (o_step!=0); o_hprev = o_sel ? h_prev : 0; o_cell_x = {o_hprev, x_reg}.
//  o_last = o_h_valid & (o_step==len_reg-1). i_start while busy ignored; i_len changes after
//   start have no effect. i_len = 2^TW-1 runs full range; o_step never wraps.
//  All outputs registered or decoded from state/registers only; no input->output comb path
//   except none (o_x_ready, o_h_valid decode state).
// STRUCTURE
//  Shared header lstm_ctrl_defs.vh: state encodings (IDLE/LOAD/EVAL/EMIT/DONE, 3-bit),
//   default LAT/TW. One FSM plus lat_cnt and step counters in this module; no sub-module
//   required. h_prev register lives here; lstm wrapper feedback register not used with it.
// TESTING
//  len=3, x always valid, ready always 1, LAT=2: 3 h outputs, each 3 clk after x accept,
//   o_sel 0,1,1; o_last on 3rd; o_done 1 clk after 3rd handshake.
//  Step 0 cell input: h_prev preloaded nonzero from prior run -> o_cell_x top word = 0.
//  Backpressure: i_h_ready low 5 clk in EMIT -> o_h/o_c/o_h_valid stable, no new x accepted.
//  i_len=0 start -> o_busy 1 clk, o_done pulse, o_h_valid never asserted.
//  i_start pulsed during EVAL and DONE -> ignored; len_reg unchanged.
//  rst low during EVAL of step 1 -> all outputs 0 immediately; next start runs cleanly from step 0.

Source files
------------

// File: rtl/lstm_seq_ctrl_pkg.sv
// lstm_seq_ctrl_pkg: state encodings and default sizing shared by the LSTM sequencer
package lstm_seq_ctrl_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int LAT_DEF = 2;
  localparam int TW_DEF  = 8;
endpackage

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps one LSTM cell over a sequence, owning the h(t-1) feedback register
module lstm_seq_ctrl
  import lstm_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM   = 3,
  parameter int LAT   = LAT_DEF,
  parameter int TW    = TW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [TW-1:0]            i_len,
  input  logic                     i_x_valid,
  input  logic [(NUM-1)*WIDTH-1:0] i_x,
  output logic                     o_x_ready,
  output logic [NUM*WIDTH-1:0]     o_cell_x,
  output logic                     o_sel,
  input  logic [WIDTH-1:0]         i_h,
  input  logic [WIDTH-1:0]         i_c,
  output logic                     o_h_valid,
  input  logic                     i_h_ready,
  output logic [WIDTH-1:0]         o_h,
  output logic [WIDTH-1:0]         o_c,
  output logic [TW-1:0]            o_step,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done
);
  logic [2:0]                 state_q, state_d;
  logic [7:0]                 lat_q, lat_d;
  logic [TW-1:0]              step_q, step_d, len_q, len_d;
  logic [(NUM-1)*WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]           hprev_q, hprev_d, h_q, h_d, c_q, c_d;
  logic                       at_last;

  assign at_last   = step_q == len_q - TW'(1);
  assign o_x_ready = state_q == S_LOAD;
  assign o_h_valid = state_q == S_EMIT;
  assign o_busy    = state_q != S_IDLE;
  assign o_done    = state_q == S_DONE;
  assign o_sel     = step_q != '0;
  assign o_last    = o_h_valid & at_last;
  assign o_cell_x  = {o_sel ? hprev_q : '0, x_q};
  assign o_step    = step_q;
  assign o_h       = h_q;
  assign o_c       = c_q;

  // sequencing FSM: accept x, wait the cell latency, hold h/c until taken, repeat per step
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    step_d  = step_q;
    len_d   = len_q;
    x_d     = x_q;
    hprev_d = hprev_q;
    h_d     = h_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        len_d   = i_len;
        step_d  = '0;
        state_d = (i_len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: if (i_x_valid) begin
        x_d     = i_x;
        lat_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: if (lat_q == 8'(LAT - 1)) begin
        h_d     = i_h;
        c_d     = i_c;
        hprev_d = i_h;
        state_d = S_EMIT;
      end else lat_d = lat_q + 8'd1;
      S_EMIT: if (i_h_ready) begin
        state_d = at_last ? S_DONE : S_LOAD;
        step_d  = at_last ? step_q : step_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      x_q     <= '0;
      hprev_q <= '0;
      h_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      step_q  <= step_d;
      len_q   <= len_d;
      x_q     <= x_d;
      hprev_q <= hprev_d;
      h_q     <= h_d;
      c_q     <= c_d;
    end
  end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: directed checks of the LSTM sequencer against a toy cell model
module tb_lstm_seq_ctrl;
  logic         clk = 0;
  logic         rst = 0;
  logic         i_start = 0;
  logic [7:0]   i_len = 0;
  logic         i_x_valid = 0;
  logic [63:0]  i_x = 0;
  logic         o_x_ready;
  logic [95:0]  o_cell_x;
  logic         o_sel;
  logic [31:0]  i_h, i_c;
  logic         o_h_valid;
  logic         i_h_ready = 0;
  logic [31:0]  o_h, o_c;
  logic [7:0]   o_step;
  logic         o_last, o_busy, o_done;
  int checks = 0;
  int failures = 0;

  localparam logic [63:0] X0 = {32'h2, 32'h1};
  localparam logic [63:0] X1 = {32'h5, 32'h4};
  localparam logic [63:0] X2 = {32'h8, 32'h7};
  localparam logic [63:0] X3 = {32'hA, 32'h5};
  localparam logic [63:0] X4 = {32'h1, 32'h2};

  lstm_seq_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_x_valid(i_x_valid), .i_x(i_x), .o_x_ready(o_x_ready),
    .o_cell_x(o_cell_x), .o_sel(o_sel), .i_h(i_h), .i_c(i_c),
    .o_h_valid(o_h_valid), .i_h_ready(i_h_ready), .o_h(o_h), .o_c(o_c),
    .o_step(o_step), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // toy cell: h = hprev + x0 + 1, c = x1 + 0x10
  assign i_h = o_cell_x[95:64] + o_cell_x[31:0] + 32'd1;
  assign i_c = o_cell_x[63:32] + 32'h10;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_busy", 96'(o_busy), 96'd0);
    chk("rst_ctl", 96'({o_x_ready, o_h_valid, o_done, o_sel, o_last}), 96'd0);
    chk("rst_data", 96'({o_h, o_c, o_step}), 96'd0);
    chk("rst_cellx", o_cell_x, 96'd0);
    rst = 1;
    tick();
    // run 1: len=3, x always valid, ready always high
    i_len = 3; i_start = 1; i_x_valid = 1; i_x = X0; i_h_ready = 1;
    tick();
    i_start = 0; i_len = 9;
    chk("r1_load0", 96'({o_x_ready, o_busy, o_sel}), 96'b110);
    tick();
    chk("r1_cellx0", o_cell_x, {32'd0, X0});
    i_x = X1;
    tick();
    chk("r1_eval_noval", 96'({o_h_valid, o_x_ready}), 96'd0);
    tick();
    chk("r1_emit0_hc", 96'({o_h_valid, o_h, o_c}), {31'd0, 1'b1, 32'h2, 32'h12});
    chk("r1_emit0_step", 96'({o_last, o_step, o_sel}), {86'd0, 1'b0, 8'd0, 1'b0});
    tick();
    chk("r1_load1", 96'({o_x_ready, o_step, o_sel}), {86'd0, 1'b1, 8'd1, 1'b1});
    tick();
    chk("r1_cellx1", o_cell_x, {32'h2, X1});
    i_x = X2;
    tick(); tick();
    chk("r1_emit1", 96'({o_h_valid, o_last, o_h, o_c}), {30'd0, 2'b10, 32'h7, 32'h15});
    tick();
    tick();
    chk("r1_cellx2", o_cell_x, {32'h7, X2});
    i_start = 1; i_len = 5;
    tick();
    i_start = 0;
    chk("r1_eval_start_ign", 96'({o_busy, o_h_valid, o_step}), {86'd0, 2'b10, 8'd2});
    tick();
    chk("r1_emit2", 96'({o_h_valid, o_last, o_h, o_c}), {30'd0, 2'b11, 32'hF, 32'h18});
    tick();
    chk("r1_done", 96'({o_done, o_busy, o_h_valid, o_x_ready}), 96'b1100);
    i_start = 1; i_len = 0;
    tick();
    i_start = 0;
    chk("r1_idle", 96'({o_done, o_busy}), 96'd0);
    tick();
    chk("r1_done_start_ign", 96'({o_done, o_busy}), 96'd0);
    // run 2: h_prev holds 0xF, step 0 must mask it; then 5 cycles of backpressure
    i_len = 2; i_start = 1; i_x = X3; i_h_ready = 0;
    tick();
    i_start = 0;
    tick();
    chk("r2_cellx0_masked", o_cell_x, {32'd0, X3});
    i_x = X4;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("r2_bp_hold", 96'({o_h_valid, o_x_ready, o_h, o_c}), {30'd0, 2'b10, 32'h6, 32'h1A});
      tick();
    end
    chk("r2_bp_step", 96'({o_h_valid, o_step}), {87'd0, 1'b1, 8'd0});
    i_h_ready = 1;
    tick();
    chk("r2_load1", 96'({o_x_ready, o_step}), {87'd0, 1'b1, 8'd1});
    tick();
    chk("r2_cellx1", o_cell_x, {32'h6, X4});
    tick(); tick();
    chk("r2_emit1", 96'({o_h_valid, o_last, o_h, o_c}), {30'd0, 2'b11, 32'h9, 32'h11});
    tick();
    chk("r2_done", 96'(o_done), 96'd1);
    tick();
    // run 3: zero-length sequence
    i_len = 0; i_start = 1;
    tick();
    i_start = 0;
    chk("r3_zero_done", 96'({o_busy, o_done, o_h_valid, o_x_ready}), 96'b1100);
    tick();
    chk("r3_zero_idle", 96'({o_busy, o_done, o_h_valid}), 96'd0);
    // run 4: reset during EVAL of step 1, then a clean one-step run
    i_len = 3; i_start = 1; i_x = X0;
    tick();
    i_start = 0;
    tick(); tick(); tick();
    chk("r4_emit0", 96'({o_h_valid, o_h}), {63'd0, 1'b1, 32'h2});
    tick(); tick();
    chk("r4_eval1", 96'({o_busy, o_step, o_sel}), {86'd0, 1'b1, 8'd1, 1'b1});
    rst = 0;
    #1;
    chk("r4_async_ctl", 96'({o_busy, o_x_ready, o_h_valid, o_done, o_sel, o_last}), 96'd0);
    chk("r4_async_data", 96'({o_h, o_c, o_step}), 96'd0);
    chk("r4_async_cellx", o_cell_x, 96'd0);
    tick();
    chk("r4_no_done", 96'({o_done, o_busy}), 96'd0);
    rst = 1;
    tick();
    i_len = 1; i_start = 1; i_x = X1;
    tick();
    i_start = 0;
    chk("r4_restart_load", 96'({o_x_ready, o_step}), {87'd0, 1'b1, 8'd0});
    tick();
    chk("r4_restart_cellx", o_cell_x, {32'd0, X1});
    tick(); tick();
    chk("r4_restart_emit", 96'({o_h_valid, o_last, o_h, o_c}), {30'd0, 2'b11, 32'h5, 32'h15});
    tick();
    chk("r4_restart_done", 96'({o_done, o_busy}), 96'b11);
    tick();
    chk("r4_restart_idle", 96'({o_done, o_busy}), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
